// File: rtl/phase2_vec_loader_pkg.sv
// Shared definitions for the phase2 vector loader: lane geometry, FSM state
// codes and the frame-length clamp.
package phase2_vec_loader_pkg;

    localparam int DW    = 8;
    localparam int N     = 8;
    localparam int N_bit = 3;

    localparam logic [N_bit:0] LEN_MAX = (N_bit + 1)'(N);
    localparam logic [N_bit:0] LEN_ONE = (N_bit + 1)'(1);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_X = 3'd1;
    localparam logic [2:0] ST_LOAD_H = 3'd2;
    localparam logic [2:0] ST_LOAD_Y = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    // A requested length of 0 or anything beyond N means a full vector.
    function automatic logic [N_bit:0] clamp_len(input logic [N_bit:0] c);
        if ((c == '0) || (c > LEN_MAX)) begin
            return LEN_MAX;
        end
        return c;
    endfunction

endpackage

// File: rtl/phase2_vec_loader_if.sv
// Byte-in / vector-out bus of the phase2 vector loader.
// master = byte source and vector consumer, slave = the loader itself.
interface phase2_vec_loader_if;
    import phase2_vec_loader_pkg::*;

    logic                in_valid;
    logic                in_ready;
    logic [DW-1:0]       in_data;
    logic                out_valid;
    logic                out_ready;
    logic [DW*N-1:0]     x_col;
    logic [DW*N-1:0]     h;
    logic [DW*N-1:0]     y;
    logic [N_bit:0]      len;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, x_col, h, y, len
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, x_col, h, y, len
    );

endinterface

// File: rtl/phase2_vec_loader_lane_ctr.sv
// Lane index counter: clear beats load beats increment; increment wraps to 0
// once the last active lane (len-1) has been reached.
module phase2_vec_loader_lane_ctr
    import phase2_vec_loader_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           clr,
    input  logic           ld,
    input  logic [N_bit:0] ld_val,
    input  logic           inc,
    input  logic [N_bit:0] len,
    output logic [N_bit:0] cnt,
    output logic           tc
);

    logic [N_bit:0] cnt_q;
    logic [N_bit:0] cnt_d;

    assign tc  = (cnt_q == (len - LEN_ONE));
    assign cnt = cnt_q;

    // Next count: clear, load, or increment with wrap at the terminal lane.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (ld) begin
            cnt_d = ld_val;
        end else if (inc) begin
            cnt_d = tc ? '0 : (cnt_q + LEN_ONE);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/phase2_vec_loader.sv
// Packs a byte frame (len x bytes, len h bytes, len y bytes) into the x_col,
// h and y vectors and holds them with out_valid until the consumer takes them.
module phase2_vec_loader
    import phase2_vec_loader_pkg::*;
(
    input  logic           clk,
    input  logic           resetn,
    input  logic           flush,
    input  logic [N_bit:0] cfg_len,
    phase2_vec_loader_if.slave bus
);

    logic [2:0]      state_q, state_d;
    logic [N_bit:0]  len_q, len_d;
    logic [DW*N-1:0] x_q, x_d;
    logic [DW*N-1:0] h_q, h_d;
    logic [DW*N-1:0] y_q, y_d;
    logic            out_valid_q, out_valid_d;
    logic            in_ready_q, in_ready_d;

    logic            accept;
    logic [N_bit:0]  len_new;
    logic [N_bit:0]  lane_cnt;
    logic            lane_tc;
    logic            ctr_ld;
    logic            ctr_inc;
    logic [N_bit:0]  ctr_ld_val;
    logic [N-1:0]    lane_oh;
    logic [N-1:0]    we_x, we_h, we_y;

    assign accept  = bus.in_valid && in_ready_q;
    assign len_new = clamp_len(cfg_len);

    // A one-lane frame has no further x lanes, so the counter restarts at 0
    // for the h group instead of moving on to lane 1.
    assign ctr_ld     = accept && (state_q == ST_IDLE);
    assign ctr_ld_val = (len_new == LEN_ONE) ? '0 : LEN_ONE;
    assign ctr_inc    = accept && ((state_q == ST_LOAD_X) ||
                                   (state_q == ST_LOAD_H) ||
                                   (state_q == ST_LOAD_Y));

    phase2_vec_loader_lane_ctr u_lane_ctr (
        .clk    (clk),
        .resetn (resetn),
        .clr    (flush),
        .ld     (ctr_ld),
        .ld_val (ctr_ld_val),
        .inc    (ctr_inc),
        .len    (len_q),
        .cnt    (lane_cnt),
        .tc     (lane_tc)
    );

    // One-hot lane decode gated by the vector the current state is filling.
    // The first byte of a frame always lands in x lane 0.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_lane
            assign lane_oh[gi] = (lane_cnt == (N_bit + 1)'(gi));
            assign we_x[gi] = accept &&
                              (((state_q == ST_LOAD_X) && lane_oh[gi]) ||
                               ((state_q == ST_IDLE) && (gi == 0)));
            assign we_h[gi] = accept && (state_q == ST_LOAD_H) && lane_oh[gi];
            assign we_y[gi] = accept && (state_q == ST_LOAD_Y) && lane_oh[gi];
        end
    endgenerate

    // Next-state logic: flush wins; otherwise start/fill/advance/release.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        x_d         = x_q;
        h_d         = h_q;
        y_d         = y_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            state_d     = ST_IDLE;
            len_d       = '0;
            x_d         = '0;
            h_d         = '0;
            y_d         = '0;
            out_valid_d = 1'b0;
        end else begin
            // New frame wipes the previous vectors so short frames read zero above len.
            if (ctr_ld) begin
                len_d = len_new;
                x_d   = '0;
                h_d   = '0;
                y_d   = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (we_x[i]) x_d[DW*i +: DW] = bus.in_data;
                if (we_h[i]) h_d[DW*i +: DW] = bus.in_data;
                if (we_y[i]) y_d[DW*i +: DW] = bus.in_data;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) state_d = (len_new == LEN_ONE) ? ST_LOAD_H : ST_LOAD_X;
                end
                ST_LOAD_X: begin
                    if (accept && lane_tc) state_d = ST_LOAD_H;
                end
                ST_LOAD_H: begin
                    if (accept && lane_tc) state_d = ST_LOAD_Y;
                end
                ST_LOAD_Y: begin
                    if (accept && lane_tc) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                end
            endcase
        end
        in_ready_d = (state_d != ST_HOLD);
    end

    // State, vector and handshake registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            x_q         <= '0;
            h_q         <= '0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            x_q         <= x_d;
            h_q         <= h_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.x_col     = x_q;
    assign bus.h         = h_q;
    assign bus.y         = y_q;
    assign bus.len       = len_q;

endmodule

// File: tb/tb_phase2_vec_loader.sv
// Directed + randomized bench for phase2_vec_loader with a frame-level model.
module tb_phase2_vec_loader;

    logic       clk = 1'b0;
    logic       resetn;
    logic       flush;
    logic [3:0] cfg_len;

    phase2_vec_loader_if bus ();

    phase2_vec_loader dut (
        .clk     (clk),
        .resetn  (resetn),
        .flush   (flush),
        .cfg_len (cfg_len),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [7:0] fb [24];
    int         exp_len;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference packing: lane i of a group holds byte (base+i), lanes >= n are zero.
    function automatic logic [63:0] pack(input int base, input int n);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = fb[base + i];
        return r;
    endfunction

    task automatic send(input logic [7:0] d, input int bubbles);
        int n;
        repeat (bubbles) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("send_timeout", 64'(n), 64'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic check_vectors(input string tag);
        chk({tag, "_len"}, 64'(bus.len), 64'(exp_len));
        chk({tag, "_x"}, bus.x_col, pack(0, exp_len));
        chk({tag, "_h"}, bus.h, pack(exp_len, exp_len));
        chk({tag, "_y"}, bus.y, pack(2 * exp_len, exp_len));
    endtask

    // Send one full frame; cfg_len is scrambled after the first byte since it must be ignored.
    task automatic send_frame(input logic [3:0] cfg, input bit rand_bytes, input bit bubbles,
                              input string tag);
        exp_len = (cfg == 0 || cfg > 8) ? 8 : int'(cfg);
        if (rand_bytes) for (int i = 0; i < 3 * exp_len; i++) fb[i] = 8'($urandom_range(0, 255));
        cfg_len = cfg;
        for (int i = 0; i < 3 * exp_len; i++) begin
            if (i == 3 * exp_len - 1) chk({tag, "_ov_before_last"}, 64'(bus.out_valid), 64'(0));
            send(fb[i], bubbles ? $urandom_range(0, 2) : 0);
            if (i == 0) cfg_len = 4'($urandom);
        end
        @(negedge clk);
        chk({tag, "_ov"}, 64'(bus.out_valid), 64'(1));
        chk({tag, "_in_ready_hold"}, 64'(bus.in_ready), 64'(0));
        check_vectors(tag);
    endtask

    task automatic release_hold(input string tag);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_ov_after_release"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_in_ready_after_release"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic check_cleared(input string tag);
        chk({tag, "_ov"}, 64'(bus.out_valid), 64'(0));
        chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
        chk({tag, "_len"}, 64'(bus.len), 64'(0));
        chk({tag, "_x"}, bus.x_col, 64'(0));
        chk({tag, "_h"}, bus.h, 64'(0));
        chk({tag, "_y"}, bus.y, 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ready_seen;
        logic [63:0] x_hold;

        resetn        = 1'b0;
        flush         = 1'b0;
        cfg_len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_cleared("reset");
        resetn = 1'b1;

        // len=1 directed frame
        fb[0] = 8'h9C; fb[1] = 8'h5E; fb[2] = 8'h44;
        send_frame(4'd1, 1'b0, 1'b0, "len1");
        chk("len1_x_literal", bus.x_col, 64'h9C);

        // Backpressure in HOLD with a byte on offer
        x_hold = bus.x_col;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        ready_seen   = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.in_ready) ready_seen++;
        end
        chk("bp_in_ready_cycles", 64'(ready_seen), 64'(0));
        chk("bp_ov", 64'(bus.out_valid), 64'(1));
        check_vectors("bp");
        bus.in_valid = 1'b0;
        release_hold("bp");
        chk("bp_x_kept_in_idle", bus.x_col, x_hold);

        // len=2 directed frame clears the old lanes
        fb[0] = 8'hFF; fb[1] = 8'hFC; fb[2] = 8'hDF;
        fb[3] = 8'hFC; fb[4] = 8'h04; fb[5] = 8'h08;
        send_frame(4'd2, 1'b0, 1'b0, "len2");
        chk("len2_x_literal", bus.x_col, 64'hFCFF);
        chk("len2_h_literal", bus.h, 64'hFCDF);
        chk("len2_y_literal", bus.y, 64'h0804);
        release_hold("len2");

        // Clamp with bubbles
        send_frame(4'd0, 1'b1, 1'b1, "clamp0");
        release_hold("clamp0");
        send_frame(4'd9, 1'b1, 1'b1, "clamp9");
        release_hold("clamp9");

        // Randomized frame lengths
        for (int k = 0; k < 4; k++) begin
            send_frame(4'($urandom_range(1, 8)), 1'b1, 1'b1, "rand");
            release_hold("rand");
        end

        // Flush coinciding with the 4th byte of a len=4 frame
        cfg_len = 4'd4;
        for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 0);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        flush        = 1'b1;
        @(posedge clk);
        #1;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        check_cleared("flush");
        send_frame(4'd3, 1'b1, 1'b0, "after_flush");
        release_hold("after_flush");

        // Reset asserted mid LOAD_H
        cfg_len = 4'd3;
        for (int i = 0; i < 4; i++) send(8'($urandom_range(1, 255)), 0);
        @(negedge clk);
        resetn = 1'b0;
        #1;
        check_cleared("rst_mid");
        @(negedge clk);
        resetn = 1'b1;

        // Back-to-back frames with out_ready tied high
        bus.out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send_frame(4'd3, 1'b1, 1'b0, "b2b");
            @(negedge clk);
            chk("b2b_ov_pulse_end", 64'(bus.out_valid), 64'(0));
        end
        bus.out_ready = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
